// File: rtl/dmem_bus_arbiter.sv
// Two-requester arbiter for the data-memory/peripheral bus.
// Pipeline MEM stage (C) has priority; the UART loader (D) is served through a starvation counter and a bounded burst.
module dmem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_gnt,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              owner
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    S_C  = 2'd0,
    S_SW = 2'd1,
    S_D  = 2'd2,
    S_BK = 2'd3
  } state_t;

  state_t          state_r;
  logic [WW-1:0]   wait_cnt_r;
  logic [BW-1:0]   beat_cnt_r;
  logic            owner_r;
  logic            c_req_s;
  logic            d_req_s;

  assign c_req_s = c_rd | c_wr;
  assign d_req_s = d_rd | d_wr;

  // Ownership FSM with starvation and burst counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_C;
      wait_cnt_r <= '0;
      beat_cnt_r <= '0;
      owner_r    <= 1'b0;
    end else begin
      case (state_r)
        S_C: begin
          if (d_req_s && (!c_req_s || (wait_cnt_r == WAIT_LAST))) begin
            state_r <= S_SW;
            owner_r <= 1'b1;
          end else begin
            state_r <= S_C;
            owner_r <= 1'b0;
          end
          // Saturating count of cycles D has been pre-empted by C.
          if (!d_req_s) begin
            wait_cnt_r <= '0;
          end else if (c_req_s && (wait_cnt_r != WAIT_LAST)) begin
            wait_cnt_r <= wait_cnt_r + WW'(1);
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        S_SW: begin
          state_r    <= S_D;
          owner_r    <= 1'b1;
          wait_cnt_r <= '0;
        end
        S_D: begin
          owner_r <= 1'b1;
          if (!d_req_s) begin
            state_r <= S_BK;
          end else if (beat_cnt_r == BEAT_LAST) begin
            state_r <= S_BK;
          end else begin
            state_r    <= S_D;
            beat_cnt_r <= beat_cnt_r + BW'(1);
          end
        end
        S_BK: begin
          state_r    <= S_C;
          owner_r    <= 1'b0;
          beat_cnt_r <= '0;
        end
        default: begin
          state_r    <= S_C;
          owner_r    <= 1'b0;
          wait_cnt_r <= '0;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

  // Bus mux and handshake outputs; everything is held at zero while reset is low.
  always_comb begin
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    c_rdata = '0;
    d_rdata = '0;
    c_stall = 1'b0;
    d_gnt   = 1'b0;
    if (!reset) begin
      m_rd = 1'b0;
    end else begin
      case (state_r)
        S_C: begin
          m_rd    = c_rd & ~c_wr;
          m_wr    = c_wr;
          m_addr  = c_addr;
          m_wdata = c_wdata;
          c_rdata = m_rdata;
        end
        S_D: begin
          c_stall = c_req_s;
          if (d_req_s) begin
            d_gnt   = 1'b1;
            m_rd    = d_rd & ~d_wr;
            m_wr    = d_wr;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            d_rdata = m_rdata;
          end else begin
            d_gnt = 1'b0;
          end
        end
        S_SW, S_BK: begin
          c_stall = c_req_s;
        end
        default: begin
          c_stall = 1'b0;
        end
      endcase
    end
  end

  assign owner = owner_r;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level ownership model and a reference memory.
module tb_dmem_bus_arbiter;

  localparam int MAX_WAIT  = 8;
  localparam int BURST_MAX = 4;

  logic        clk;
  logic        reset;
  logic        c_rd, c_wr, d_rd, d_wr;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        c_stall, d_gnt, m_rd, m_wr, owner;

  dmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .c_rd(c_rd), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_stall(c_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_gnt(d_gnt),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-side memory: combinational read, write on the rising edge.
  bit [31:0] bus_mem [256];
  assign m_rdata = bus_mem[m_addr[9:2]];
  always @(posedge clk) if (m_wr) bus_mem[m_addr[9:2]] <= m_wdata;

  // Reference model state: who owns the bus and where D is in its ownership period.
  bit [31:0] ref_mem [256];
  bit  own_d, enter_bubble, leave_bubble;
  int  beats, blocked;
  logic        e_m_rd, e_m_wr, e_c_stall, e_d_gnt, e_owner;
  logic [31:0] e_m_addr, e_m_wdata, e_c_rdata, e_d_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic        obs_gnt, obs_stall, obs_owner, obs_m_wr, last_e_stall;
  logic [31:0] obs_m_addr, obs_d_rdata, obs_c_rdata;
  int run_q [$];
  int got, budget;
  logic [31:0] last_rdata, last_crdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    bit cr, dr;
    cr = c_rd | c_wr;
    dr = d_rd | d_wr;
    {e_m_rd, e_m_wr, e_c_stall, e_d_gnt, e_owner} = 5'b0;
    {e_m_addr, e_m_wdata, e_c_rdata, e_d_rdata} = 128'b0;
    if (reset && !own_d) begin
      e_m_wr    = c_wr;
      e_m_rd    = c_rd & ~c_wr;
      e_m_addr  = c_addr;
      e_m_wdata = c_wdata;
      e_c_rdata = ref_mem[c_addr[9:2]];
    end else if (reset) begin
      e_owner   = 1'b1;
      e_c_stall = cr;
      if (!enter_bubble && !leave_bubble && dr) begin
        e_d_gnt   = 1'b1;
        e_m_wr    = d_wr;
        e_m_rd    = d_rd & ~d_wr;
        e_m_addr  = d_addr;
        e_m_wdata = d_wdata;
        e_d_rdata = ref_mem[d_addr[9:2]];
      end
    end
  endtask

  task automatic model_advance();
    bit cr, dr;
    cr = c_rd | c_wr;
    dr = d_rd | d_wr;
    if (!reset) begin
      own_d = 0; enter_bubble = 0; leave_bubble = 0; beats = 0; blocked = 0;
    end else if (!own_d) begin
      if (c_wr) ref_mem[c_addr[9:2]] = c_wdata;
      if (dr && (!cr || blocked >= MAX_WAIT - 1)) begin
        own_d = 1; enter_bubble = 1; blocked = 0;
      end else if (dr) blocked++;
      else blocked = 0;
    end else if (enter_bubble) begin
      enter_bubble = 0; beats = 0;
    end else if (leave_bubble) begin
      own_d = 0; leave_bubble = 0;
    end else if (dr) begin
      if (d_wr) ref_mem[d_addr[9:2]] = d_wdata;
      beats++;
      if (beats == BURST_MAX) leave_bubble = 1;
    end else leave_bubble = 1;
  endtask

  // One bus cycle: sample on the falling edge, compare, advance the model, return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    model_outputs();
    chk("m_rd", m_rd, e_m_rd);
    chk("m_wr", m_wr, e_m_wr);
    chk("m_addr", m_addr, e_m_addr);
    chk("m_wdata", m_wdata, e_m_wdata);
    chk("c_rdata", c_rdata, e_c_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("c_stall", c_stall, e_c_stall);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("owner", owner, e_owner);
    obs_gnt = d_gnt; obs_stall = c_stall; obs_owner = owner; obs_m_wr = m_wr;
    obs_m_addr = m_addr; obs_d_rdata = d_rdata; obs_c_rdata = c_rdata;
    last_e_stall = e_c_stall;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic d_xfer(input int n, input logic [31:0] base, input bit wr);
    int run;
    run = 0; got = 0; budget = 0;
    run_q.delete();
    while (got < n && budget < 200) begin
      d_addr  = base + 32'(got * 4);
      d_wdata = 32'hA000_0000 | d_addr;
      d_wr = wr; d_rd = !wr;
      cyc();
      budget++;
      if (obs_gnt) begin
        got++; run++;
        last_rdata = obs_d_rdata; last_crdata = obs_c_rdata;
      end else if (run > 0) begin
        run_q.push_back(run); run = 0;
      end
    end
    if (run > 0) run_q.push_back(run);
    d_wr = 1'b0; d_rd = 1'b0;
    chk("xfer_done", 32'(got), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int blk, stl, gnts, mism;
    bit seen_stall, done;
    c_rd = 0; c_wr = 0; d_rd = 0; d_wr = 0;
    c_addr = 0; c_wdata = 0; d_addr = 0; d_wdata = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    c_wr = 1; c_addr = 32'h10; c_wdata = 32'h1111_1111;
    d_wr = 1; d_addr = 32'h20; d_wdata = 32'h2222_2222;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("rel_m_addr", obs_m_addr, 32'h10);
    chk("rel_m_wr", {31'b0, obs_m_wr}, 32'd1);
    c_wr = 0; d_wr = 0;
    repeat (4) cyc();

    // Idle hand-over: 3 beats after one turnaround bubble.
    d_xfer(3, 32'h100, 1'b1);
    chk("idle_cycles", 32'(budget), 32'd5);
    chk("idle_runs", 32'(run_q.size()), 32'd1);
    repeat (3) cyc();
    chk("idle_owner_back", {31'b0, obs_owner}, 32'd0);
    chk("mem_100", bus_mem[32'h100 >> 2], 32'hA000_0100);
    chk("mem_108", bus_mem[32'h108 >> 2], 32'hA000_0108);

    // Burst cap: 10 beats split 4/4/2.
    d_xfer(10, 32'h140, 1'b1);
    chk("burst_groups", 32'(run_q.size()), 32'd3);
    if (run_q.size() == 3) begin
      chk("burst_g0", 32'(run_q[0]), 32'd4);
      chk("burst_g1", 32'(run_q[1]), 32'd4);
      chk("burst_g2", 32'(run_q[2]), 32'd2);
    end else chk("burst_shape", 32'(run_q.size()), 32'd3);
    repeat (3) cyc();

    // Read path.
    c_wr = 1; c_addr = 32'h200; c_wdata = 32'hDEAD_BEEF;
    cyc();
    c_wr = 0;
    d_xfer(1, 32'h200, 1'b0);
    chk("rd_d_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("rd_c_rdata", last_crdata, 32'h0);
    repeat (3) cyc();

    // Starvation: C and D both request continuously.
    c_wr = 1; c_addr = 32'h60; c_wdata = 32'h5A5A_0060;
    d_wr = 1; d_addr = 32'h80; d_wdata = 32'h0BAD_0080;
    blk = 0; stl = 0; gnts = 0; seen_stall = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if (obs_stall) begin
        seen_stall = 1; stl++;
        if (obs_gnt) gnts++;
      end else if (seen_stall) done = 1;
      else if (!obs_owner) blk++;
    end
    chk("starve_done", {31'b0, done}, 32'd1);
    chk("starve_blocked", 32'(blk), 32'(MAX_WAIT));
    chk("starve_stall", 32'(stl), 32'(BURST_MAX + 2));
    chk("starve_gnts", 32'(gnts), 32'(BURST_MAX));
    chk("starve_resume", obs_m_addr, 32'h60);
    c_wr = 0; d_wr = 0;
    repeat (4) cyc();

    // Async reset between beats 2 and 3 of a burst.
    d_wr = 1; got = 0; budget = 0;
    while (got < 2 && budget < 20) begin
      d_addr = 32'h300 + 32'(got * 4); d_wdata = 32'hC000_0000 | d_addr;
      cyc(); budget++;
      if (obs_gnt) got++;
    end
    d_addr = 32'h308; d_wdata = 32'hC000_0308;
    reset = 1'b0;
    #1;
    chk("abort_owner", {31'b0, owner}, 32'd0);
    chk("abort_gnt", {31'b0, d_gnt}, 32'd0);
    chk("abort_m_wr", {31'b0, m_wr}, 32'd0);
    cyc();
    reset = 1'b1;
    d_wr = 0;
    cyc();
    chk("abort_mem_308", bus_mem[32'h308 >> 2], 32'h0);
    chk("abort_mem_304", bus_mem[32'h304 >> 2], 32'hC000_0304);

    // Random traffic; C holds its request while stalled.
    for (int i = 0; i < 400; i++) begin
      if (!last_e_stall) begin
        case ($urandom_range(0, 3))
          0: begin c_rd = 0; c_wr = 0; end
          1: begin c_rd = 1; c_wr = 0; end
          2: begin c_rd = 0; c_wr = 1; end
          default: begin c_rd = 1; c_wr = 1; end
        endcase
        c_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        c_wdata = $urandom;
      end
      d_rd = ($urandom_range(0, 4) == 0);
      d_wr = ($urandom_range(0, 2) == 0);
      d_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      d_wdata = $urandom;
      cyc();
    end
    c_rd = 0; c_wr = 0; d_rd = 0; d_wr = 0;
    repeat (3) cyc();

    mism = 0;
    for (int k = 0; k < 256; k++) if (bus_mem[k] !== ref_mem[k]) mism++;
    chk("mem_final", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single data-memory/peripheral bus between two requesters: the pipeline MEM stage (requester C) and the UART debug/program-loader engine (requester D).
- C has priority. D is guaranteed service through a starvation counter and a bounded burst.
- While D owns the bus, a stall is raised toward the hazard logic. The stall freezes PC, IF/ID, ID/EX and EX/MEM, so C holds its request stable.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 8, consecutive blocked cycles D tolerates before forced handover (>=1)
- BURST_MAX, 4, max D beats per ownership period (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- c_rd, c_wr  in  1 each  C read/write request
- c_addr  in  ADDR_W  C address
- c_wdata  in  DATA_W  C write data
- c_rdata  out  DATA_W  C read data
- c_stall  out  1  C must hold its request; access not performed this cycle
- d_rd, d_wr  in  1 each  D read/write request
- d_addr  in  ADDR_W  D address
- d_wdata  in  DATA_W  D write data
- d_rdata  out  DATA_W  D read data, valid when d_gnt=1
- d_gnt  out  1  D beat performed this cycle
- m_rd, m_wr  out  1 each  to memory/peripheral bus
- m_addr  out  ADDR_W  to memory/peripheral bus
- m_wdata  out  DATA_W  to memory/peripheral bus
- m_rdata  in  DATA_W  combinational read data from bus
- owner  out  1  0 = C, 1 = D (debug visibility)

Behaviour:
- Request definition: c_req = c_rd|c_wr; d_req = d_rd|d_wr. Asserting rd and wr together is illegal; the design treats it as a write.
- Bus timing: memory reads are combinational; writes commit on the clk edge. Each granted access is one cycle.
- FSM states: S_C (reset state), S_SW, S_D, S_BK.
- S_C:
  - Bus driven from C.
  - c_stall=0, d_gnt=0.
  - wait_cnt increments while d_req & c_req; saturates at MAX_WAIT-1; clears when d_req=0.
  - Go to S_SW when d_req & (!c_req | wait_cnt==MAX_WAIT-1).
- S_SW (1-cycle turnaround bubble):
  - m_rd=m_wr=0.
  - c_stall=c_req, d_gnt=0.
  - Always go to S_D. wait_cnt clears.
- S_D:
  - Bus driven from D when d_req; d_gnt=d_req; c_stall=c_req.
  - beat_cnt increments on each granted beat.
  - Go to S_BK when d_req=0, or when a beat is granted with beat_cnt==BURST_MAX-1.
- S_BK (1-cycle bubble):
  - m_rd=m_wr=0; c_stall=c_req.
  - beat_cnt clears. Go to S_C.
- Data return:
  - c_rdata = m_rdata when owner=0, else 0.
  - d_rdata = m_rdata when d_gnt, else 0.
- owner = 1 in S_SW, S_D and S_BK.
- Reset (async, while reset=0):
  - State S_C; wait_cnt=0; beat_cnt=0.
  - Outputs forced: m_rd=m_wr=0, c_stall=0, d_gnt=0, owner=0.
  - m_addr, m_wdata, c_rdata and d_rdata driven 0.
- Reset mid-burst aborts D. D receives no acknowledgement for the aborted beat; the loader must retry.
- Boundaries:
  - Simultaneous c_req & d_req with wait_cnt < MAX_WAIT-1: C is served; D waits.
  - MAX_WAIT=1: D takes over on the first cycle it requests.
  - d_req drops in S_SW: S_D is still entered, finds no request, and exits via S_BK.
  - A C request issued while owner=1 is not lost; it is served on the first S_C cycle.
  - An aborted beat never reaches the bus. A granted beat always completes.
- No combinational path exists from c_req/d_req into state; only into outputs.

Test Plan:
- Reset: reset=0 with c_wr=1 and d_wr=1 → m_wr=0, c_stall=0, d_gnt=0, owner=0. Release → first cycle c_addr appears on m_addr with m_wr=1.
- Idle bus hand-over: c_req=0, D issues 3 write beats to 0x100/0x104/0x108 → one S_SW bubble, then 3 consecutive d_gnt cycles, then S_BK, then owner=0. Memory holds all 3 words.
- Starvation, MAX_WAIT=8: C requests every cycle, D requests continuously → D is blocked exactly 8 cycles. Then c_stall=1 for 1+BURST_MAX+1=6 cycles and d_gnt pulses 4 times. C then resumes with its held address and data.
- Burst cap: D requests 10 beats with c_req=0 → grants in groups of 4,4,2. Each group is bracketed by S_BK/S_C/S_SW cycles.
- Read path: preload 0xDEADBEEF at 0x200; D reads 0x200 → d_rdata=0xDEADBEEF in the d_gnt cycle, c_rdata=0.
- Async reset mid-burst: assert reset=0 between beats 2 and 3 → immediately owner=0, d_gnt=0. Beat 3 is never written; after release the FSM is in S_C with counters at 0.
